lane_renderer: RTL and testbench

LANE_RENDERER -- requirements
Module: lane_renderer

---
 rtl/kc_render_pkg.sv | 53 +++++
 rtl/sweep_counter.sv | 50 +++++
 rtl/lane_renderer.sv | 155 +++++++++++++++
 tb/tb_lane_renderer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kc_render_pkg.sv
// rtl/kc_render_pkg.sv - shared geometry, colours and command encoding for the lane renderer
package kc_render_pkg;

    localparam int unsigned BOARD_X0   = 48;
    localparam int unsigned BOARD_W    = 64;
    localparam int unsigned BOARD_H    = 120;
    localparam int unsigned LANE_W     = 16;
    localparam int unsigned NOTE_INSET = 2;
    localparam int unsigned NOTE_W     = 12;
    localparam int unsigned SLOT_H     = 8;
    localparam int unsigned SLOT_COUNT = 13;
    localparam int unsigned NOTE_H     = SLOT_H * SLOT_COUNT;
    localparam int unsigned HITLINE_Y  = 104;

    localparam logic [2:0] COL_BLACK   = 3'b000;
    localparam logic [2:0] COL_DIVIDER = 3'b111;
    localparam logic [2:0] COL_HITLINE = 3'b110;
    localparam logic [2:0] COL_LANE1   = 3'b010;
    localparam logic [2:0] COL_LANE2   = 3'b100;
    localparam logic [2:0] COL_LANE3   = 3'b110;
    localparam logic [2:0] COL_LANE4   = 3'b001;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_ERASE = 3'd1,
        CMD_BOARD = 3'd2,
        CMD_NOTE1 = 3'd3,
        CMD_NOTE2 = 3'd4,
        CMD_NOTE3 = 3'd5,
        CMD_NOTE4 = 3'd6
    } cmd_t;

    // Fixed priority: erase beats board beats the note lanes in lane order
    function automatic cmd_t select_cmd(input logic erase, input logic board, input logic [3:0] notes);
        if (erase)         return CMD_ERASE;
        else if (board)    return CMD_BOARD;
        else if (notes[0]) return CMD_NOTE1;
        else if (notes[1]) return CMD_NOTE2;
        else if (notes[2]) return CMD_NOTE3;
        else if (notes[3]) return CMD_NOTE4;
        else               return CMD_NONE;
    endfunction

    function automatic logic [2:0] lane_colour(input logic [1:0] lane);
        case (lane)
            2'd0:    return COL_LANE1;
            2'd1:    return COL_LANE2;
            2'd2:    return COL_LANE3;
            default: return COL_LANE4;
        endcase
    endfunction

endpackage

// File: rtl/sweep_counter.sv
// rtl/sweep_counter.sv - x/y raster counter with runtime extent, clear/advance and last flag
module sweep_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_advance,
    input  logic [7:0] i_width,
    input  logic [6:0] i_height,
    output logic [7:0] o_cx,
    output logic [6:0] o_cy,
    output logic       o_last
);

    logic [7:0] r_cx;
    logic [6:0] r_cy;
    logic [7:0] w_bx;
    logic [6:0] w_by;
    logic       w_row_end;
    logic       w_col_end;

    // Clear together with advance means "restart at the origin and step past it"
    assign w_bx      = i_clear ? 8'd0 : r_cx;
    assign w_by      = i_clear ? 7'd0 : r_cy;
    assign w_row_end = (w_bx == i_width - 8'd1);
    assign w_col_end = (w_by == i_height - 7'd1);

    assign o_cx   = r_cx;
    assign o_cy   = r_cy;
    assign o_last = (r_cx == i_width - 8'd1) && (r_cy == i_height - 7'd1);

    // Raster step, cx fastest; a lone clear parks the counter at the origin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cx <= 8'd0;
            r_cy <= 7'd0;
        end else if (i_advance) begin
            if (w_row_end) begin
                r_cx <= 8'd0;
                r_cy <= w_col_end ? 7'd0 : w_by + 7'd1;
            end else begin
                r_cx <= w_bx + 8'd1;
                r_cy <= w_by;
            end
        end else if (i_clear) begin
            r_cx <= 8'd0;
            r_cy <= 7'd0;
        end
    end

endmodule

// File: rtl/lane_renderer.sv
// rtl/lane_renderer.sv - board/note sweep renderer for a 160x120 VGA adapter (option: RENDER_HITLINE_EN)
module lane_renderer
    import kc_render_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        erase_notes,
    input  logic        draw_board,
    input  logic        draw_notes1,
    input  logic        draw_notes2,
    input  logic        draw_notes3,
    input  logic        draw_notes4,
    input  logic        plot,
    input  logic [12:0] lane_notes1,
    input  logic [12:0] lane_notes2,
    input  logic [12:0] lane_notes3,
    input  logic [12:0] lane_notes4,
    output logic        updating,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        writeEn
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t      r_state;
    cmd_t        r_cmd;
    logic [12:0] r_snap [4];
    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic [2:0]  r_colour;
    logic        r_we;

    cmd_t        w_sel;
    cmd_t        w_cmd;
    logic        w_start;
    logic        w_emit;
    logic        w_cnt_last;
    logic        w_last_pixel;
    logic [7:0]  w_cx;
    logic [6:0]  w_cy;
    logic [7:0]  w_px;
    logic [6:0]  w_py;
    logic [7:0]  w_width;
    logic [6:0]  w_height;
    logic [7:0]  w_x0;
    logic [1:0]  w_lane;
    logic        w_is_note;
    logic [12:0] w_notes_in;
    logic [12:0] w_notes;
    logic [3:0]  w_slot;
    logic [2:0]  w_colour;

    assign w_sel = select_cmd(erase_notes, draw_board,
                              {draw_notes4, draw_notes3, draw_notes2, draw_notes1});

    // r_cmd remembers the command last swept, so a held command is not redrawn
    assign w_start      = (w_sel != CMD_NONE) && (w_sel != r_cmd);
    assign w_emit       = w_start || ((r_state == ST_BUSY) && (w_sel == r_cmd));
    assign w_cmd        = w_start ? w_sel : r_cmd;
    assign w_px         = w_start ? 8'd0 : w_cx;
    assign w_py         = w_start ? 7'd0 : w_cy;
    assign w_last_pixel = w_emit && !w_start && w_cnt_last;
    assign updating     = !reset && (w_sel != CMD_NONE) && !w_last_pixel;

    sweep_counter u_sweep (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_start || !w_emit || w_last_pixel),
        .i_advance (w_emit && !w_last_pixel),
        .i_width   (w_width),
        .i_height  (w_height),
        .o_cx      (w_cx),
        .o_cy      (w_cy),
        .o_last    (w_cnt_last)
    );

    // Sweep geometry of the active command; lanes sit LANE_W apart inside the board
    always_comb begin
        w_width   = 8'(BOARD_W);
        w_height  = 7'(BOARD_H);
        w_lane    = 2'd0;
        w_is_note = 1'b0;
        case (w_cmd)
            CMD_NOTE1: begin w_lane = 2'd0; w_is_note = 1'b1; end
            CMD_NOTE2: begin w_lane = 2'd1; w_is_note = 1'b1; end
            CMD_NOTE3: begin w_lane = 2'd2; w_is_note = 1'b1; end
            CMD_NOTE4: begin w_lane = 2'd3; w_is_note = 1'b1; end
            default:   begin w_lane = 2'd0; w_is_note = 1'b0; end
        endcase
        if (w_is_note) begin
            w_width  = 8'(NOTE_W);
            w_height = 7'(NOTE_H);
            w_x0     = 8'(BOARD_X0 + NOTE_INSET) + {2'b00, w_lane, 4'b0000};
        end else begin
            w_x0     = 8'(BOARD_X0);
        end
    end

    // Pixel colour; the first pixel of a sweep reads the live notes being snapshotted
    always_comb begin
        case (w_lane)
            2'd0:    w_notes_in = lane_notes1;
            2'd1:    w_notes_in = lane_notes2;
            2'd2:    w_notes_in = lane_notes3;
            default: w_notes_in = lane_notes4;
        endcase
        w_notes  = w_start ? w_notes_in : r_snap[w_lane];
        w_slot   = w_py[6:3];
        w_colour = COL_BLACK;
        if (w_cmd == CMD_BOARD) begin
            if (w_px[3:0] == 4'd0) w_colour = COL_DIVIDER;
`ifdef RENDER_HITLINE_EN
            if (w_py == 7'(HITLINE_Y)) w_colour = COL_HITLINE;
`endif
        end else if (w_is_note) begin
            if (w_notes[w_slot]) w_colour = lane_colour(w_lane);
        end
    end

    // Control FSM with the registered pixel port and the note snapshot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cmd    <= CMD_NONE;
            for (int i = 0; i < 4; i++) r_snap[i] <= 13'd0;
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_colour <= 3'd0;
            r_we     <= 1'b0;
        end else begin
            r_cmd   <= w_sel;
            r_state <= (w_emit && !w_last_pixel) ? ST_BUSY : ST_IDLE;
            r_we    <= w_emit && plot;
            if (w_emit) begin
                r_x      <= w_x0 + w_px;
                r_y      <= w_py;
                r_colour <= w_colour;
            end
            if (w_start) begin
                r_snap[0] <= lane_notes1;
                r_snap[1] <= lane_notes2;
                r_snap[2] <= lane_notes3;
                r_snap[3] <= lane_notes4;
            end
        end
    end

    assign x       = r_x;
    assign y       = r_y;
    assign colour  = r_colour;
    assign writeEn = r_we;

endmodule

// File: tb/tb_lane_renderer.sv
// tb/tb_lane_renderer.sv - randomized self-checking bench for lane_renderer against a pixel-list model
module tb_lane_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  cmd_bits;
    logic        plot;
    logic [12:0] ln [4];
    logic        updating;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        writeEn;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [17:0] cap_q [$];
    int          cap_t [$];

    lane_renderer dut (
        .clk         (clk),
        .reset       (reset),
        .erase_notes (cmd_bits[5]),
        .draw_board  (cmd_bits[4]),
        .draw_notes1 (cmd_bits[3]),
        .draw_notes2 (cmd_bits[2]),
        .draw_notes3 (cmd_bits[1]),
        .draw_notes4 (cmd_bits[0]),
        .plot        (plot),
        .lane_notes1 (ln[0]),
        .lane_notes2 (ln[1]),
        .lane_notes3 (ln[2]),
        .lane_notes4 (ln[3]),
        .updating    (updating),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .writeEn     (writeEn)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (writeEn === 1'b1) begin
            cap_q.push_back({x, y, colour});
            cap_t.push_back(cyc);
        end
    end

    // Commands: 1 erase, 2 board, 3..6 notes lane 1..4
    function automatic logic [5:0] cmd_to_bits(input int cmd);
        logic [5:0] top;
        top = 6'b100000;
        return top >> (cmd - 1);
    endfunction

    function automatic int sweep_size(input int cmd);
        return (cmd <= 2) ? 64 * 120 : 12 * 104;
    endfunction

    function automatic int lane_col(input int lane);
        case (lane)
            0:       return 2;
            1:       return 4;
            2:       return 6;
            default: return 1;
        endcase
    endfunction

    // k-th pixel of a sweep, straight from the board/lane geometry
    function automatic logic [17:0] exp_pix(input int cmd, input int k, input logic [12:0] notes);
        int px, py, xx, c, lane;
        c = 0;
        if (cmd <= 2) begin
            px = k % 64;
            py = k / 64;
            xx = 48 + px;
            if (cmd == 2) begin
                c = ((xx - 48) % 16 == 0) ? 7 : 0;
`ifdef RENDER_HITLINE_EN
                if (py == 104) c = 6;
`endif
            end
        end else begin
            lane = cmd - 3;
            px   = k % 12;
            py   = k / 12;
            xx   = 48 + 16 * lane + 2 + px;
            c    = notes[py / 8] ? lane_col(lane) : 0;
        end
        return {8'(xx), 7'(py), 3'(c)};
    endfunction

    function automatic int cap_col(input int idx);
        if (idx < cap_q.size()) return int'(cap_q[idx][2:0]);
        return -1;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Hold the current inputs for n cycles, tallying cycles with updating low
    task automatic hold(input int n, input bit scramble, output int lows, output int first_low);
        lows      = 0;
        first_low = -1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (updating !== 1'b1) begin
                lows++;
                if (first_low < 0) first_low = c;
            end
            @(posedge clk);
            #1;
            if (scramble) for (int i = 0; i < 4; i++) ln[i] = 13'($urandom);
        end
    endtask

    task automatic idle_cycles(input int n);
        cmd_bits = 6'b000000;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        cap_q.delete();
        cap_t.delete();
    endtask

    // Compare p captured pixels from qstart against the model; report first mismatch
    task automatic check_seg(input string tag, input int cmd, input logic [12:0] notes,
                             input int qstart, input int p);
        int  idx;
        bit  found;
        idx   = p - 1;
        found = 0;
        for (int i = 0; i < p && !found; i++) begin
            if (qstart + i >= cap_q.size() || cap_q[qstart + i] !== exp_pix(cmd, i, notes)) begin
                idx   = i;
                found = 1;
            end
        end
        if (qstart + idx < cap_q.size())
            chk($sformatf("%s_pix%0d", tag, idx), int'(cap_q[qstart + idx]), int'(exp_pix(cmd, idx, notes)));
        else
            chk($sformatf("%s_missing%0d", tag, idx), cap_q.size(), qstart + p);
    endtask

    initial begin
        int          lows, first_low, bad;
        logic [12:0] snap;

        for (int i = 0; i < 4; i++) ln[i] = 13'($urandom);
        reset    = 1'b1;
        plot     = 1'b1;
        cmd_bits = 6'b010000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_updating", updating, 0);
        chk("rst_writeEn", writeEn, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        cmd_bits = 6'b000000;
        reset    = 1'b0;
        @(posedge clk);
        #1;
        clear_cap();

        // Full board sweep with the command held well past its end
        cmd_bits = cmd_to_bits(2);
        hold(8000, 1'b1, lows, first_low);
        chk("board_upd_lows", lows, 1);
        chk("board_upd_low_cycle", first_low, 7680);
        idle_cycles(3);
        chk("board_count", cap_q.size(), 7680);
        check_seg("board", 2, 13'd0, 0, 7680);
        chk("board_48_5", cap_col(5 * 64 + 0), 7);
        chk("board_49_5", cap_col(5 * 64 + 1), 0);
`ifdef RENDER_HITLINE_EN
        bad = 0;
        for (int i = 0; i < 64; i++) if (cap_col(104 * 64 + i) != 6) bad++;
        chk("hitline_bad", bad, 0);
`else
        chk("board_48_104", cap_col(104 * 64 + 0), 7);
        chk("board_49_104", cap_col(104 * 64 + 1), 0);
`endif
        clear_cap();

        // Lane 2 with notes at slots 0 and 12, inputs scrambled after the snapshot
        ln[1]    = 13'h1001;
        cmd_bits = cmd_to_bits(4);
        hold(1300, 1'b1, lows, first_low);
        chk("n2_upd_low_cycle", first_low, 1248);
        idle_cycles(3);
        chk("n2_count", cap_q.size(), 1248);
        check_seg("n2", 4, 13'h1001, 0, 1248);
        chk("n2_66_0", cap_col(0), 4);
        chk("n2_66_8", cap_col(8 * 12), 0);
        chk("n2_66_96", cap_col(96 * 12), 4);
        chk("n2_77_103", cap_col(1247), 4);
        clear_cap();

        // Random notes on every lane
        for (int lane = 0; lane < 4; lane++) begin
            snap     = 13'($urandom);
            ln[lane] = snap;
            cmd_bits = cmd_to_bits(3 + lane);
            hold(1260, 1'b1, lows, first_low);
            chk($sformatf("rnd%0d_upd_lows", lane), lows, 1);
            idle_cycles(3);
            chk($sformatf("rnd%0d_count", lane), cap_q.size(), 1248);
            check_seg($sformatf("rnd%0d", lane), 3 + lane, snap, 0, 1248);
            clear_cap();
        end

        // plot low: sweep still runs but nothing is written
        plot     = 1'b0;
        cmd_bits = cmd_to_bits(6);
        hold(1300, 1'b1, lows, first_low);
        chk("noplot_upd_low_cycle", first_low, 1248);
        idle_cycles(3);
        chk("noplot_count", cap_q.size(), 0);
        plot = 1'b1;
        clear_cap();

        // Board drops for one cycle, then lane 1 starts with no gap
        cmd_bits = cmd_to_bits(2);
        hold(50, 1'b0, lows, first_low);
        cmd_bits = 6'b000000;
        @(posedge clk);
        #1;
        snap     = 13'($urandom);
        ln[0]    = snap;
        cmd_bits = cmd_to_bits(3);
        hold(1260, 1'b1, lows, first_low);
        idle_cycles(3);
        chk("switch_count", cap_q.size(), 50 + 1248);
        check_seg("switch_board", 2, 13'd0, 0, 50);
        check_seg("switch_n1", 3, snap, 50, 1248);
        if (cap_t.size() > 50) chk("switch_gap", cap_t[50] - cap_t[49], 2);
        else chk("switch_gap_missing", cap_t.size(), 51);
        clear_cap();

        // Reset at board pixel 300, then a fresh sweep with the command still held
        cmd_bits = cmd_to_bits(2);
        hold(300, 1'b0, lows, first_low);
        reset = 1'b1;
        #1;
        chk("abort_writeEn", writeEn, 0);
        chk("abort_updating", updating, 0);
        chk("abort_prior_writes", cap_q.size(), 299);
        repeat (2) @(posedge clk);
        #1;
        clear_cap();
        reset = 1'b0;
        hold(7700, 1'b0, lows, first_low);
        chk("restart_upd_low_cycle", first_low, 7680);
        idle_cycles(3);
        chk("restart_count", cap_q.size(), 7680);
        check_seg("restart", 2, 13'd0, 0, 7680);
        clear_cap();

        // Erase wins over lane 3
        cmd_bits = cmd_to_bits(1) | cmd_to_bits(5);
        hold(7700, 1'b1, lows, first_low);
        chk("erase_upd_lows", lows, 1);
        idle_cycles(3);
        chk("erase_count", cap_q.size(), 7680);
        check_seg("erase", 1, 13'd0, 0, 7680);
        clear_cap();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
